// File: rtl/meteor_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : meteor_scheduler_if
// Brief    : Game-core side bundle of the meteor scheduler (control in, meteors out)
// Revision : 1.0 - initial release
// ============================================================================
interface meteor_scheduler_if;
    logic        frame_tick;
    logic        enable;
    logic        restart;
    logic [15:0] score;
    logic        meteor0_alive;
    logic        meteor1_alive;
    logic [9:0]  meteor0_x;
    logic [9:0]  meteor0_y;
    logic [2:0]  meteor0_size;
    logic [9:0]  meteor1_x;
    logic [9:0]  meteor1_y;
    logic [2:0]  meteor1_size;
    logic [1:0]  level;
    logic        slot0_falling;
    logic        slot1_falling;

    modport master (
        output frame_tick, enable, restart, score, meteor0_alive, meteor1_alive,
        input  meteor0_x, meteor0_y, meteor0_size, meteor1_x, meteor1_y, meteor1_size,
        input  level, slot0_falling, slot1_falling
    );

    modport slave (
        input  frame_tick, enable, restart, score, meteor0_alive, meteor1_alive,
        output meteor0_x, meteor0_y, meteor0_size, meteor1_x, meteor1_y, meteor1_size,
        output level, slot0_falling, slot1_falling
    );
endinterface
`default_nettype wire

// File: rtl/meteor_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : meteor_scheduler
// Brief    : Two-slot meteor spawner: LFSR placement, per-slot WAIT/FALL FSM
// Revision : 1.0 - initial release
// ============================================================================
module meteor_scheduler (
    input  logic              clk,
    input  logic              reset_n,
    meteor_scheduler_if.slave bus
);
    localparam logic [9:0]  c_PARK_Y    = 10'd1000;
    localparam logic [10:0] c_SCREEN_H  = 11'd480;
    localparam logic [10:0] c_Y_MAX     = c_SCREEN_H - 11'd1;
    localparam logic [9:0]  c_X_MIN     = 10'd64;
    localparam logic [9:0]  c_X_RESET   = 10'd320;
    localparam logic [7:0]  c_INIT_DLY0 = 8'd30;
    localparam logic [7:0]  c_INIT_DLY1 = 8'd90;
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [0:0]  c_ST_WAIT   = 1'b0;
    localparam logic [0:0]  c_ST_FALL   = 1'b1;

    logic [15:0] r_lfsr;
    logic [0:0]  r_state [2];
    logic [7:0]  r_cnt   [2];
    logic [9:0]  r_y     [2];
    logic [9:0]  r_x     [2];
    logic [2:0]  r_size  [2];
    logic [1:0]  r_level;
    logic [1:0]  r_kill;
    logic [1:0]  r_alive_q;

    logic [0:0]  w_state_nx [2];
    logic [7:0]  w_cnt_nx   [2];
    logic [9:0]  w_y_nx     [2];
    logic [9:0]  w_x_nx     [2];
    logic [2:0]  w_size_nx  [2];
    logic [10:0] w_ysum     [2];
    logic [1:0]  w_level_nx;
    logic [1:0]  w_kill_nx;
    logic [1:0]  w_alive;
    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_tick;
    logic        w_lfsr_fb;
    logic [2:0]  w_speed;
    logic [7:0]  w_reload_raw;
    logic [7:0]  w_reload_sub;
    logic [7:0]  w_reload;
    logic [9:0]  w_spawn_x;
    logic [2:0]  w_spawn_size;

    assign w_tick    = bus.frame_tick & bus.enable;
    assign w_alive   = {bus.meteor1_alive, bus.meteor0_alive};
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_speed   = {1'b0, r_level} + 3'd1;

    // At level 3 the reload can go below zero; it saturates at 0 instead of wrapping.
    assign w_reload_raw = 8'd8 + {2'b00, r_lfsr[5:0]};
    assign w_reload_sub = {4'b0000, r_level, 2'b00};
    assign w_reload     = (w_reload_raw < w_reload_sub) ? 8'd0 : (w_reload_raw - w_reload_sub);

    assign w_spawn_x    = c_X_MIN + {1'b0, r_lfsr[9:1]};
    assign w_spawn_size = (r_lfsr[15:13] > 3'd4) ? (r_lfsr[15:13] - 3'd5) : r_lfsr[15:13];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_ysum[i] = {1'b0, r_y[i]} + {8'b0, w_speed};
        end
    end

    always_comb begin
        w_level_nx = r_level;
        if (bus.restart) begin
            w_level_nx = 2'd0;
        end else if (w_tick) begin
            w_level_nx = (bus.score >= 16'd1024) ? 2'd3 : bus.score[9:8];
        end
    end

    always_comb begin
        // A fresh kill on a tick clock survives the clear so it is not lost.
        w_kill_nx = (r_alive_q & ~w_alive) | (r_kill & {2{~w_tick}});
        w_req     = '0;
        for (int i = 0; i < 2; i++) begin
            w_req[i] = (r_state[i] == c_ST_WAIT) && (r_cnt[i] == 8'd0);
        end
        w_grant = {w_req[1] & ~w_req[0], w_req[0]};

        for (int i = 0; i < 2; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_y_nx[i]     = r_y[i];
            w_x_nx[i]     = r_x[i];
            w_size_nx[i]  = r_size[i];
            if (bus.restart) begin
                w_state_nx[i] = c_ST_WAIT;
                w_y_nx[i]     = c_PARK_Y;
                w_cnt_nx[i]   = (i == 0) ? c_INIT_DLY0 : c_INIT_DLY1;
            end else if (w_tick) begin
                case (r_state[i])
                    c_ST_WAIT: begin
                        if (r_cnt[i] != 8'd0) begin
                            w_cnt_nx[i] = r_cnt[i] - 8'd1;
                        end else if (w_grant[i]) begin
                            w_state_nx[i] = c_ST_FALL;
                            w_y_nx[i]     = 10'd0;
                            w_x_nx[i]     = w_spawn_x;
                            w_size_nx[i]  = w_spawn_size;
                        end
                    end
                    c_ST_FALL: begin
                        if (r_kill[i] || (w_ysum[i] > c_Y_MAX)) begin
                            w_state_nx[i] = c_ST_WAIT;
                            w_y_nx[i]     = c_PARK_Y;
                            w_cnt_nx[i]   = w_reload;
                        end else begin
                            w_y_nx[i] = w_ysum[i][9:0];
                        end
                    end
                endcase
            end
        end
        if (bus.restart) begin
            w_kill_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr    <= c_LFSR_SEED;
            r_level   <= 2'd0;
            r_kill    <= 2'b00;
            r_alive_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= c_ST_WAIT;
                r_cnt[i]   <= (i == 0) ? c_INIT_DLY0 : c_INIT_DLY1;
                r_y[i]     <= c_PARK_Y;
                r_x[i]     <= c_X_RESET;
                r_size[i]  <= 3'd0;
            end
        end else begin
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            r_level   <= w_level_nx;
            r_kill    <= w_kill_nx;
            r_alive_q <= w_alive;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_y[i]     <= w_y_nx[i];
                r_x[i]     <= w_x_nx[i];
                r_size[i]  <= w_size_nx[i];
            end
        end
    end

    assign bus.meteor0_x     = r_x[0];
    assign bus.meteor0_y     = r_y[0];
    assign bus.meteor0_size  = r_size[0];
    assign bus.meteor1_x     = r_x[1];
    assign bus.meteor1_y     = r_y[1];
    assign bus.meteor1_size  = r_size[1];
    assign bus.level         = r_level;
    assign bus.slot0_falling = (r_state[0] == c_ST_FALL);
    assign bus.slot1_falling = (r_state[1] == c_ST_FALL);
endmodule
`default_nettype wire

// File: tb/tb_meteor_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_meteor_scheduler
// Brief    : Scoreboard bench for meteor_scheduler with a cycle reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_meteor_scheduler;
    logic clk = 1'b0;
    logic reset_n;

    meteor_scheduler_if bus ();

    meteor_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic        m_fall [2];
    int          m_cnt  [2];
    int          m_y    [2];
    int          m_x    [2];
    int          m_size [2];
    int          m_level;
    logic        m_kill [2];
    logic        m_aq   [2];
    logic [49:0] sb_q [$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [49:0] pack_model();
        return {10'(m_y[0]), 10'(m_x[0]), 3'(m_size[0]),
                10'(m_y[1]), 10'(m_x[1]), 3'(m_size[1]),
                2'(m_level), m_fall[0], m_fall[1]};
    endfunction

    task automatic model_clock();
        logic tk;
        logic spawned;
        logic al [2];
        logic kd [2];
        int   sp;
        int   r;
        int   s;
        al[0] = bus.meteor0_alive;
        al[1] = bus.meteor1_alive;
        tk    = bus.frame_tick && bus.enable;
        for (int i = 0; i < 2; i++) kd[i] = m_aq[i] && !al[i];
        if (bus.restart) begin
            for (int i = 0; i < 2; i++) begin
                m_fall[i] = 1'b0;
                m_y[i]    = 1000;
                m_kill[i] = 1'b0;
            end
            m_cnt[0] = 30;
            m_cnt[1] = 90;
            m_level  = 0;
        end else begin
            if (tk) begin
                spawned = 1'b0;
                sp      = 1 + m_level;
                r       = 8 + int'(m_lfsr[5:0]) - 4 * m_level;
                if (r < 0) r = 0;
                for (int i = 0; i < 2; i++) begin
                    if (m_fall[i]) begin
                        if (m_kill[i] || (m_y[i] + sp >= 480)) begin
                            m_y[i]    = 1000;
                            m_fall[i] = 1'b0;
                            m_cnt[i]  = r;
                        end else begin
                            m_y[i] = m_y[i] + sp;
                        end
                    end else if (m_cnt[i] > 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end else if (!spawned) begin
                        spawned   = 1'b1;
                        m_fall[i] = 1'b1;
                        m_y[i]    = 0;
                        m_x[i]    = 64 + int'(m_lfsr[9:1]);
                        s         = int'(m_lfsr[15:13]);
                        m_size[i] = (s >= 5) ? s - 5 : s;
                    end
                end
                m_level = (bus.score >= 16'd1024) ? 3 : int'(bus.score[9:8]);
            end
            for (int i = 0; i < 2; i++) m_kill[i] = kd[i] || (m_kill[i] && !tk);
        end
        for (int i = 0; i < 2; i++) m_aq[i] = al[i];
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_fall[i] = 1'b0;
                m_y[i]    = 1000;
                m_x[i]    = 320;
                m_size[i] = 0;
                m_kill[i] = 1'b0;
                m_aq[i]   = 1'b1;
            end
            m_cnt[0] = 30;
            m_cnt[1] = 90;
            m_level  = 0;
            sb_q.delete();
        end else begin
            model_clock();
            sb_q.push_back(pack_model());
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && sb_q.size() > 0) begin
            check_value("outputs",
                {bus.meteor0_y, bus.meteor0_x, bus.meteor0_size,
                 bus.meteor1_y, bus.meteor1_x, bus.meteor1_size,
                 bus.level, bus.slot0_falling, bus.slot1_falling},
                sb_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    // One frame every 4 clocks; the tick edge is the first posedge after the call.
    task automatic tick(input bit drop0 = 1'b0);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        if (drop0) bus.meteor0_alive = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    int          first0, first1, y1_at90, x0_spawn, y0_spawn, size0_spawn;
    int          last_y0, y_a, y_b;
    bit          parked, found, both;
    logic [15:0] lf;

    task automatic count_spawns();
        first0 = 0; first1 = 0; y1_at90 = 0;
        x0_spawn = 0; y0_spawn = -1; size0_spawn = 7;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus.slot0_falling && first0 == 0) begin
                first0      = k;
                x0_spawn    = int'(bus.meteor0_x);
                y0_spawn    = int'(bus.meteor0_y);
                size0_spawn = int'(bus.meteor0_size);
            end
            if (bus.slot1_falling && first1 == 0) first1 = k;
            if (k == 90) y1_at90 = int'(bus.meteor1_y);
        end
        check_value("spawn0_tick", first0, 31);
        check_value("spawn1_tick", first1, 91);
        check_value("slot1_parked_while_waiting", y1_at90, 1000);
        check_value("spawn0_y", y0_spawn, 0);
        check_value("spawn0_x_in_range", (x0_spawn >= 64 && x0_spawn <= 575), 1);
        check_value("spawn0_size_le4", (size0_spawn <= 4), 1);
    endtask

    initial begin
        bus.frame_tick    = 1'b0;
        bus.enable        = 1'b1;
        bus.restart       = 1'b0;
        bus.score         = 16'd0;
        bus.meteor0_alive = 1'b1;
        bus.meteor1_alive = 1'b1;
        reset_n           = 1'b0;

        #12;
        check_value("rst_y0", bus.meteor0_y, 1000);
        check_value("rst_x0", bus.meteor0_x, 320);
        check_value("rst_size1", bus.meteor1_size, 0);
        check_value("rst_falling", {bus.slot0_falling, bus.slot1_falling}, 0);
        check_value("rst_level", bus.level, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        count_spawns();

        // slot0 falls 1 px/frame and parks after y=479
        parked  = 1'b0;
        last_y0 = 0;
        for (int k = 0; k < 600 && !parked; k++) begin
            last_y0 = int'(bus.meteor0_y);
            tick();
            if (!bus.slot0_falling) parked = 1'b1;
        end
        check_value("bottom_park_seen", parked, 1);
        check_value("bottom_last_y", last_y0, 479);
        check_value("bottom_park_y", bus.meteor0_y, 1000);

        // kill slot1 between ticks
        bus.meteor1_alive = 1'b0;
        @(negedge clk);
        tick();
        check_value("kill_y1", bus.meteor1_y, 1000);
        check_value("kill_falling1", bus.slot1_falling, 0);
        bus.meteor1_alive = 1'b1;
        tick();
        check_value("revive_no_action", {bus.meteor1_y, bus.slot1_falling}, {10'd1000, 1'b0});

        // high score: level 3, 4 px/frame
        bus.score = 16'd1100;
        tick();
        check_value("level3", bus.level, 3);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (bus.slot0_falling) found = 1'b1;
        end
        check_value("lvl3_spawn_seen", found, 1);
        y_a = int'(bus.meteor0_y);
        tick();
        y_b = int'(bus.meteor0_y);
        check_value("lvl3_step", y_b - y_a, 4);

        // freeze, then restart
        bus.enable = 1'b0;
        repeat (20) tick();
        bus.enable = 1'b1;
        pulse_restart();
        check_value("restart_y", {bus.meteor0_y, bus.meteor1_y}, {10'd1000, 10'd1000});
        check_value("restart_level", bus.level, 0);
        count_spawns();

        // steer a kill so both counters reach zero on the same frame
        bus.score = 16'd0;
        found     = 1'b0;
        for (int a = 0; a < 40 && !found; a++) begin
            pulse_restart();
            for (int k = 0; k < 90 && !found; k++) begin
                lf = m_lfsr;
                repeat (4) lf = lfsr_step(lf);
                if (m_fall[0] && !m_fall[1] && m_level == 0 && m_y[0] < 470 &&
                    m_cnt[1] >= 10 && (8 + int'(lf[5:0])) == m_cnt[1] - 2) begin
                    tick(1'b1);
                    tick();
                    bus.meteor0_alive = 1'b1;
                    found = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        check_value("arb_setup_found", found, 1);
        both = 1'b0;
        for (int k = 0; k < 100 && !both; k++) begin
            if (!m_fall[0] && !m_fall[1] && m_cnt[0] == 0 && m_cnt[1] == 0) both = 1'b1;
            else tick();
        end
        check_value("arb_both_zero", both, 1);
        tick();
        check_value("arb_slot0_first", {bus.slot0_falling, bus.slot1_falling}, 2'b10);
        tick();
        check_value("arb_slot1_next", {bus.slot0_falling, bus.slot1_falling}, 2'b11);

        // asynchronous reset in mid-cycle
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_value("async_rst_y", {bus.meteor0_y, bus.meteor1_y}, {10'd1000, 10'd1000});
        check_value("async_rst_x", {bus.meteor0_x, bus.meteor1_x}, {10'd320, 10'd320});
        check_value("async_rst_flags", {bus.slot0_falling, bus.slot1_falling, bus.level}, 0);
        #10;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        repeat (35) tick();
        check_value("post_reset_spawn0", bus.slot0_falling, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/meteor_scheduler.md
METEOR_SCHEDULER -- requirements
Module: meteor_scheduler

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, reset; one clock; reset is asynchronous and active-low.
REQ-002 SHALL have inputs: frame_tick 1 (one-clk pulse per frame); enable 1 (1 = play, 0 = freeze); restart 1 (one-clk pulse); score 16 (game score); meteor0_alive 1, meteor1_alive 1 (from game core).
REQ-003 SHALL have outputs: meteor0_x 10, meteor0_y 10, meteor0_size 3, meteor1_x 10, meteor1_y 10, meteor1_size 3 (centre and size class 0..4); level 2 (difficulty); slot0_falling 1, slot1_falling 1 (slot in FALL).
REQ-004 SHALL use constants PARK_Y = 1000, SCREEN_H = 480, X_MIN = 64, INIT_DLY0 = 30, INIT_DLY1 = 90.

Function
REQ-005 SHALL hold a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, that advances every clk regardless of enable and frame_tick; it SHALL never hold 0.
REQ-006 SHALL give each slot its own FSM with states WAIT and FALL, plus an 8-bit delay counter.
REQ-007 SHALL perform all state, position and counter updates only on clk cycles with frame_tick=1 and enable=1; otherwise everything holds (freeze), except the LFSR and the kill latch.
REQ-008 WAIT: counter > 0 -> decrement; counter == 0 -> spawn request.
REQ-009 Spawn arbitration: at most one spawn per frame_tick; slot0 has priority; a denied slot1 stays in WAIT with counter 0 and spawns on the next qualifying tick.
REQ-010 Spawn: y <= 0; x <= X_MIN + LFSR[9:1] (range 64..575); size <= LFSR[15:13], with 5/6/7 mapped to 0/1/2; state <= FALL.
REQ-011 FALL: y <= y + speed, where speed = 1 + level (1..4 px/frame).
REQ-012 FALL bottom exit: if y + speed > SCREEN_H-1, then y <= PARK_Y, state <= WAIT, counter <= 8 + LFSR[5:0] - 4*level.
REQ-013 Kill detect: on each clk, a 1->0 transition of meteorN_alive (against a per-clk registered copy) SHALL set killN_pending.
REQ-014 Kill handling: on the next qualifying tick with slot N in FALL, killN_pending forces y <= PARK_Y, state <= WAIT, and the REQ-012 counter reload; killN_pending is cleared on every qualifying tick.
REQ-015 Kill and bottom exit in the same tick SHALL produce one park and one reload.
REQ-016 PARK_Y SHALL sit off-screen, so a later spawn at y=0 is a y decrease that the core recognises as a respawn.
REQ-017 level SHALL be registered on frame_tick: 3 if score >= 1024, else score[9:8].
REQ-018 restart (sampled on any clk, regardless of enable/frame_tick): both slots -> WAIT, y <= PARK_Y, counters <= INIT_DLY0 / INIT_DLY1, kill latches cleared, level <= 0; the LFSR is not reseeded.
REQ-019 x and size SHALL hold their last spawn values while in WAIT.
REQ-020 slotN_falling SHALL be 1 exactly when slot N is in FALL.

Reset
REQ-021 On reset_n=0: LFSR = 16'hACE1; both slots WAIT; counters = INIT_DLY0 / INIT_DLY1; meteorN_x = 320; meteorN_y = PARK_Y; meteorN_size = 0; level = 0; kill latches and alive copies = 0/1 respectively; falling flags = 0.
REQ-022 Reset asserted mid-operation SHALL override all activity immediately, with no dependence on clk.

Verification
REQ-023 Reset, enable=1, frame_tick every 4 clk: slot0 spawns on tick 31 (y=0, x in 64..575, size <= 4) and slot1 on tick 91; meanwhile y stays 1000.
REQ-024 score=0, slot falling: y advances by 1 per tick; it parks at 1000 on the tick where y+1 > 479, and the falling flag drops.
REQ-025 score=1100: level=3, y steps by 4; reload counter lies in 0..59.
REQ-026 Force both counters to 0 on the same tick: slot0 spawns that tick, slot1 on the next tick; never both together.
REQ-027 Slot falling, alive 1->0 between ticks: next tick y=1000, state WAIT; alive 0->1 causes no action.
REQ-028 enable=0 for 20 ticks: all outputs frozen; restart pulse: both y=1000, and spawns occur 31 and 91 ticks later.
